// File: rtl/spi_pkg.sv
// Shared definitions for the SPI host arbiter: FSM encoding, command-word field
// positions, register addresses and the default widths used by the arbiter.
package spi_pkg;

  localparam int unsigned SPI_NUM_REQ_DEF     = 3;
  localparam int unsigned SPI_REQ_DW_DEF      = 16;
  localparam int unsigned SPI_ACK_DW_DEF      = 8;
  localparam int unsigned SPI_TIMEOUT_DEF     = 64;

  // Command word layout: {R/W, MB, addr[5:0], wdata[7:0]}
  localparam int unsigned SPI_CMD_READ_BIT    = 15;
  localparam int unsigned SPI_CMD_MB_BIT      = 14;

  localparam logic [5:0]  SPI_REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0]  SPI_REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0]  SPI_REG_DATAX0      = 6'h32;
  localparam logic [5:0]  SPI_REG_DATAX1      = 6'h33;
  localparam logic [5:0]  SPI_REG_DATAY0      = 6'h34;
  localparam logic [5:0]  SPI_REG_DATAY1      = 6'h35;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping around the request vector.
module rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the farthest offset down so the offset closest to ptr_i wins.
  always_comb begin
    int unsigned j;
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 32'd0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      j       = (32'(ptr_i) + 32'(k)) % N;
      idx_o   = req_i[j] ? IDX_W'(j) : idx_o;
      valid_o = valid_o | req_i[j];
    end
  end

endmodule

// File: rtl/spi_host_arbiter.sv
// Round-robin arbiter sharing one SPI host between NUM_REQ requesters, with a
// per-grant timeout and a fixed RESP/GAP turnaround between transfers.
module spi_host_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ        = SPI_NUM_REQ_DEF,
  parameter int unsigned REQ_DATA_WIDTH = SPI_REQ_DW_DEF,
  parameter int unsigned ACK_DATA_WIDTH = SPI_ACK_DW_DEF,
  parameter int unsigned TIMEOUT_CYCLES = SPI_TIMEOUT_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*REQ_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic [NUM_REQ-1:0]                req_err,
  output logic [ACK_DATA_WIDTH-1:0]         req_ack_data,
  output logic                              host_req,
  output logic [REQ_DATA_WIDTH-1:0]         host_req_data,
  input  logic                              host_ack,
  input  logic [ACK_DATA_WIDTH-1:0]         host_ack_data,
  output logic                              busy,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e                state_q, state_d;
  logic                      host_req_q, host_req_d;
  logic [REQ_DATA_WIDTH-1:0] host_req_data_q, host_req_data_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]        req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]        req_err_q, req_err_d;
  logic [ACK_DATA_WIDTH-1:0] ack_data_q, ack_data_d;

  logic                      pick_valid_s;
  logic [IDX_W-1:0]          pick_idx_s;
  logic [REQ_DATA_WIDTH-1:0] pick_data_s;
  logic [NUM_REQ-1:0]        grant_oh_s;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid_s),
    .idx_o   (pick_idx_s)
  );

  assign pick_data_s = req_data[int'(pick_idx_s)*int'(REQ_DATA_WIDTH) +: REQ_DATA_WIDTH];

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_oh
    assign grant_oh_s[i] = (grant_q == IDX_W'(i));
  end

  // Next-state and output-register logic of the arbitration FSM.
  always_comb begin
    state_d         = state_q;
    host_req_d      = host_req_q;
    host_req_data_d = host_req_data_q;
    grant_d         = grant_q;
    rr_ptr_d        = rr_ptr_q;
    cnt_d           = cnt_q;
    req_ack_d       = '0;
    req_err_d       = '0;
    ack_data_d      = ack_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d         = ST_ISSUE;
          host_req_d      = 1'b1;
          host_req_data_d = pick_data_s;
          grant_d         = pick_idx_s;
          cnt_d           = '0;
        end else begin
          state_d         = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // A host_ack on the expiry cycle takes priority over the timeout.
        if (host_ack && host_req_q) begin
          state_d    = ST_RESP;
          host_req_d = 1'b0;
          req_ack_d  = grant_oh_s;
          ack_data_d = host_ack_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_RESP;
          host_req_d = 1'b0;
          req_ack_d  = grant_oh_s;
          req_err_d  = grant_oh_s;
          ack_data_d = '1;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d  = ST_GAP;
        rr_ptr_d = IDX_W'(wrap_inc(32'(grant_q), NUM_REQ));
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        host_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      host_req_q      <= 1'b0;
      host_req_data_q <= '0;
      grant_q         <= '0;
      rr_ptr_q        <= '0;
      cnt_q           <= '0;
      req_ack_q       <= '0;
      req_err_q       <= '0;
      ack_data_q      <= '0;
    end else begin
      state_q         <= state_d;
      host_req_q      <= host_req_d;
      host_req_data_q <= host_req_data_d;
      grant_q         <= grant_d;
      rr_ptr_q        <= rr_ptr_d;
      cnt_q           <= cnt_d;
      req_ack_q       <= req_ack_d;
      req_err_q       <= req_err_d;
      ack_data_q      <= ack_data_d;
    end
  end

  assign host_req      = host_req_q;
  assign host_req_data = host_req_data_q;
  assign grant_id      = grant_q;
  assign req_ack       = req_ack_q;
  assign req_err       = req_err_q;
  assign req_ack_data  = ack_data_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_host_arbiter.sv
// Self-checking bench for spi_host_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_spi_host_arbiter;

  localparam int NR = 3;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ack;
  logic [NR-1:0]     req_err;
  logic [AW-1:0]     req_ack_data;
  logic              host_req;
  logic [DW-1:0]     host_req_data;
  logic              host_ack;
  logic [AW-1:0]     host_ack_data;
  logic              busy;
  logic [1:0]        grant_id;

  int checks = 0;
  int errors = 0;

  spi_host_arbiter #(
    .NUM_REQ        (NR),
    .REQ_DATA_WIDTH (DW),
    .ACK_DATA_WIDTH (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .req_err       (req_err),
    .req_ack_data  (req_ack_data),
    .host_req      (host_req),
    .host_req_data (host_req_data),
    .host_ack      (host_ack),
    .host_ack_data (host_ack_data),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          ack_n;
    logic [7:0]  ack_d;
    logic [7:0]  exp_d;
    bit          exp_err;
    int          exp_hi;
    bit          drop;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One isolated transfer from a single requester; ack_n is the ISSUE cycle
  // (1-based) on which host_ack is driven, values above TO mean never.
  task automatic single_txn(input vec_t v);
    int n;
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    req_data[v.id*DW +: DW] = v.data;
    host_ack = 1'b1;
    host_ack_data = 8'hEE;
    tick();
    chk("vec rise", {31'd0, host_req}, 32'd1);
    n = 0;
    while (host_req && n < 80) begin
      n++;
      chk("vec hold", {grant_id, host_req_data, req_ack}, {2'(v.id), v.data, 3'b000});
      host_ack = (n == v.ack_n);
      host_ack_data = (n == v.ack_n) ? v.ack_d : 8'($urandom);
      if (v.drop && n == 2) req_valid = '0;
      req_data[v.id*DW +: DW] = 16'($urandom);
      tick();
    end
    chk("vec hi cycles", n, v.exp_hi);
    chk("vec ack", {29'd0, req_ack}, 32'd1 << v.id);
    chk("vec err", {29'd0, req_err}, v.exp_err ? (32'd1 << v.id) : 32'd0);
    chk("vec data", {24'd0, req_ack_data}, {24'd0, v.exp_d});
    req_valid = '0;
    host_ack = 1'b1;
    tick();
    chk("vec gap", {busy, req_ack, req_err, req_ack_data}, {1'b1, 3'b000, 3'b000, v.exp_d});
    tick();
    chk("vec idle", {busy, host_req}, 2'b00);
    host_ack = 1'b0;
  endtask

  initial begin
    int got[$];
    int exp_order[4];
    int lo;
    int w;
    bit prev;
    // Randomized-phase model state.
    bit          pend[NR];
    logic [15:0] snap_d[NR];
    logic [NR-1:0] snap_v;
    int          waitg[NR];
    int          mptr, win, ack_at, hi;
    logic [15:0] latched;
    logic [7:0]  exp_d;
    bit          first;

    vecs[0] = '{0, 16'hB200, 16,  8'h5A, 8'h5A, 1'b0, 16, 1'b0};
    vecs[1] = '{1, 16'hAD00, 1,   8'h3C, 8'h3C, 1'b0, 1,  1'b0};
    vecs[2] = '{2, 16'h3108, 64,  8'h11, 8'h11, 1'b0, 64, 1'b0};
    vecs[3] = '{0, 16'hF200, 100, 8'h77, 8'hFF, 1'b1, 64, 1'b0};
    vecs[4] = '{1, 16'h2D08, 63,  8'h00, 8'h00, 1'b0, 63, 1'b1};
    vecs[5] = '{2, 16'hB500, 5,   8'hA5, 8'hA5, 1'b0, 5,  1'b0};
    exp_order = '{0, 1, 2, 0};

    req_valid = '0;
    req_data = '0;
    host_ack = 1'b0;
    host_ack_data = '0;
    rst_n = 1'b0;

    #12;
    chk("reset outputs", {host_req, host_req_data, req_ack, req_err, req_ack_data, grant_id, busy}, 32'd0);
    tick();
    rst_n = 1'b1;

    // All three requesters held: expect grants 0,1,2,0 with >=3 idle cycles between.
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 16'h1000 + 16'(i);
    lo = 0; prev = 1'b0; w = 0;
    while ((got.size() < 4 || host_req) && w < 100) begin
      tick();
      w++;
      if (host_req) begin
        if (!prev) begin
          got.push_back(int'(grant_id));
          if (got.size() > 1) chk("rr turnaround", {31'd0, lo >= 3}, 32'd1);
        end
        host_ack = 1'b1;
        lo = 0;
      end else begin
        host_ack = 1'b0;
        lo++;
      end
      prev = host_req;
    end
    chk("rr grant count", got.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("rr order", got[i], exp_order[i]);
    end
    req_valid = '0;
    host_ack = 1'b0;
    tick();
    tick();

    // Reset during the 5th ISSUE cycle; rr pointer must restart at 0.
    req_valid = 3'b101;
    tick();
    chk("pre-reset grant", {host_req, grant_id}, {1'b1, 2'd2});
    tick(); tick(); tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async drop", {host_req, req_ack, busy}, 5'b0);
    tick();
    chk("reset no ack", {29'd0, req_ack}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("regrant from 0", {host_req, grant_id}, {1'b1, 2'd0});
    host_ack = 1'b1;
    host_ack_data = 8'h42;
    tick();
    chk("regrant ack", {req_ack, req_ack_data}, {3'b001, 8'h42});
    req_valid = '0;
    host_ack = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 6; i++) single_txn(vecs[i]);

    // Randomized traffic against a transaction-level model.
    rst_n = 1'b0;
    req_valid = '0;
    host_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0; waitg[i] = 0; snap_d[i] = '0;
    end
    snap_v = '0;
    mptr = 0; win = 0; ack_at = 1; hi = 0; lo = 3; prev = 1'b0; first = 1'b1;
    latched = '0; exp_d = '0;
    for (int it = 0; it < 3000; it++) begin
      tick();
      if (host_req && !prev) begin
        int ew;
        bit starve;
        ew = -1;
        for (int k = 0; k < NR; k++) begin
          int idx;
          idx = (mptr + k) % NR;
          if (ew < 0 && snap_v[idx]) ew = idx;
        end
        chk("rand winner", {30'd0, grant_id}, ew);
        if (!first) chk("rand turnaround", {31'd0, lo >= 3}, 32'd1);
        first = 1'b0;
        win = (ew < 0) ? 0 : ew;
        latched = snap_d[win];
        starve = 1'b0;
        for (int i = 0; i < NR; i++) begin
          if (i == win) waitg[i] = 0;
          else if (snap_v[i]) waitg[i]++;
          if (waitg[i] > NR - 1) starve = 1'b1;
        end
        chk("rand starvation", {31'd0, starve}, 32'd0);
        hi = 0;
        case ($urandom % 10)
          7: ack_at = 64;
          8: ack_at = 63;
          9: ack_at = 100;
          default: ack_at = 1 + int'($urandom % 12);
        endcase
      end
      if (host_req) begin
        hi++;
        chk("rand issue", {busy, req_ack, req_err, host_req_data}, {1'b1, 3'b000, 3'b000, latched});
        host_ack = (hi == ack_at);
        host_ack_data = 8'($urandom);
        if (hi == ack_at) exp_d = host_ack_data;
        lo = 0;
      end else if (prev) begin
        chk("rand ack", {29'd0, req_ack}, 32'd1 << win);
        chk("rand err", {29'd0, req_err}, (ack_at > TO) ? (32'd1 << win) : 32'd0);
        chk("rand data", {24'd0, req_ack_data}, (ack_at > TO) ? 32'hFF : {24'd0, exp_d});
        chk("rand hi cycles", hi, (ack_at > TO) ? TO : ack_at);
        pend[win] = 1'b0;
        req_valid[win] = 1'b0;
        mptr = (win + 1) % NR;
        lo = 1;
        host_ack = 1'($urandom % 2);
        host_ack_data = 8'($urandom);
      end else begin
        chk("rand quiet", {26'd0, req_ack, req_err}, 32'd0);
        lo++;
        host_ack = 1'($urandom % 2);
        host_ack_data = 8'($urandom);
      end
      prev = host_req;
      for (int i = 0; i < NR; i++) begin
        if (!pend[i]) begin
          if ($urandom % 4 == 0) begin
            pend[i] = 1'b1;
            req_valid[i] = 1'b1;
            req_data[i*DW +: DW] = 16'($urandom);
          end
        end else if ($urandom % 2 == 0) begin
          req_data[i*DW +: DW] = 16'($urandom);
        end
      end
      snap_v = req_valid;
      for (int i = 0; i < NR; i++) snap_d[i] = req_data[i*DW +: DW];
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_host_arbiter.md
SPI_HOST_ARBITER -- requirements
Module: spi_host_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters sharing the SPI host.
REQ-002 Parameter REQ_DATA_WIDTH, default 16, width of the command word {R/W, MB, addr[5:0], wdata[7:0]}.
REQ-003 Parameter ACK_DATA_WIDTH, default 8, width of the read-back byte.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, maximum clk cycles a granted transfer waits for host_ack.
REQ-005 clk  input  1  system clock, 2 MHz; reset rst_n, asynchronous, active-low.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester request, held high until its req_ack.
REQ-008 req_data  input  NUM_REQ*REQ_DATA_WIDTH  flattened command words; requester i uses slice i.
REQ-009 req_ack  output  NUM_REQ  one-hot single-cycle completion pulse.
REQ-010 req_err  output  NUM_REQ  one-hot single-cycle timeout pulse, coincident with req_ack.
REQ-011 req_ack_data  output  ACK_DATA_WIDTH  read byte, valid while any req_ack bit is high.
REQ-012 host_req  output  1  request to the SPI host, held until host_ack.
REQ-013 host_req_data  output  REQ_DATA_WIDTH  command word forwarded to the SPI host.
REQ-014 host_ack  input  1  SPI host completion; sampled only while host_req=1.
REQ-015 host_ack_data  input  ACK_DATA_WIDTH  byte returned by the SPI host.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 grant_id  output  clog2(NUM_REQ)  index of the current or last granted requester.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, RESP and GAP.
REQ-019 IDLE: when any req_valid is high, pick a winner round-robin starting at rr_ptr; next cycle go to ISSUE with host_req=1, host_req_data latched from the winner slice, and grant_id=winner.
REQ-020 host_req_data and grant_id SHALL stay stable throughout ISSUE, even if req_data changes.
REQ-021 ISSUE: host_ack&host_req → next cycle host_req=0, state RESP, req_ack[winner]=1, req_ack_data=host_ack_data as registered.
REQ-022 ISSUE timeout: a per-grant counter starts at 0 on entry; at TIMEOUT_CYCLES-1 without host_ack → host_req=0, state RESP, req_ack[winner]=1, req_err[winner]=1, req_ack_data=all ones.
REQ-023 host_ack arriving on the same cycle as timeout expiry SHALL count as success, with no req_err.
REQ-024 RESP lasts exactly one cycle, then GAP; rr_ptr = (winner+1) mod NUM_REQ, updated on RESP exit.
REQ-025 GAP lasts exactly one cycle and ignores all req_valid, so a requester dropping its request one cycle after ack is never re-granted; then IDLE.
REQ-026 Minimum turnaround from host_ack to the next host_req SHALL be 3 cycles (RESP, GAP, IDLE decision).
REQ-027 host_ack while host_req=0 SHALL be ignored.
REQ-028 A req_valid deasserted during ISSUE SHALL NOT abort the transfer; completion is still reported.
REQ-029 Starvation bound: a continuously asserted requester SHALL be granted within NUM_REQ grants.
REQ-030 req_ack, req_err and req_ack_data SHALL be 0 in every state except RESP (req_ack_data excepted: it holds its value).

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE, host_req=0, host_req_data=0, req_ack=0, req_err=0, req_ack_data=0, grant_id=0, rr_ptr=0, timeout counter=0.
REQ-032 Reset mid-ISSUE SHALL drop host_req immediately, with no req_ack issued.

Structure
REQ-033 A shared package spi_pkg SHALL hold the FSM state encoding, the command-field constants (READ bit, MB bit, register addresses 0x2D, 0x31, 0x32–0x35), and the default widths.
REQ-034 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, pointer; outputs: valid, index), purely combinational.

Verification
REQ-035 Single requester 0, data 16'hB200, host_ack after 16 cycles with data 8'h5A → req_ack[0] for exactly 1 cycle, req_ack_data=8'h5A, host_req low the cycle after host_ack.
REQ-036 All 3 requesters held high continuously → grant order 0,1,2,0; each grant separated by at least the RESP and GAP states.
REQ-037 TIMEOUT_CYCLES=64 with host_ack never asserted → host_req high for 64 cycles, then req_ack[w]=req_err[w]=1 and req_ack_data=8'hFF.
REQ-038 host_ack coincident with the timeout cycle, data 8'h11 → req_err=0, req_ack_data=8'h11.
REQ-039 rst_n asserted in the 5th cycle of ISSUE → host_req=0 asynchronously, no req_ack; after release, the pending request is regranted starting from requester 0.
REQ-040 req_data changed mid-ISSUE → host_req_data unchanged until RESP.
